// File: rtl/accessor_pkg.sv
// Shared types, write-strobe constants and alignment helpers for the load/store accessor.
package accessor_pkg;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_e;
    typedef enum logic [1:0] {SIZE_BYTE, SIZE_HALF, SIZE_WORD} size_e;

    localparam logic [3:0] WSTRB_NONE = 4'b0000;
    localparam logic [3:0] WSTRB_BYTE = 4'b0001;
    localparam logic [3:0] WSTRB_HALF = 4'b0011;
    localparam logic [3:0] WSTRB_WORD = 4'b1111;

    function automatic logic isMisaligned(input size_e size, input logic [1:0] addrLow);
        case (size)
            SIZE_HALF: return addrLow[0];
            SIZE_WORD: return addrLow != 2'b00;
            default:   return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] wstrbFor(input size_e size, input logic [1:0] addrLow);
        case (size)
            SIZE_BYTE: return WSTRB_BYTE << addrLow;
            SIZE_HALF: return WSTRB_HALF << {addrLow[1], 1'b0};
            default:   return WSTRB_WORD;
        endcase
    endfunction

endpackage

// File: rtl/accessor_mem_align.sv
// Combinational lane steering: replicates store data across lanes and extracts/extends load data.
module accessor_mem_align
    import accessor_pkg::*;
(
    input  size_e       size_i,
    input  logic        signed_i,
    input  logic [1:0]  addrLow_i,
    input  logic [31:0] storeData_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] wdata_o,
    output logic [31:0] loadData_o
);

    logic [7:0]  byteLane;
    logic [15:0] halfLane;

    always_comb begin
        byteLane   = rdata_i[{addrLow_i, 3'b000} +: 8];
        halfLane   = addrLow_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        wdata_o    = storeData_i;
        loadData_o = rdata_i;
        case (size_i)
            SIZE_BYTE: begin
                loadData_o = {{24{signed_i & byteLane[7]}}, byteLane};
                wdata_o    = {4{storeData_i[7:0]}};
            end
            SIZE_HALF: begin
                loadData_o = {{16{signed_i & halfLane[15]}}, halfLane};
                wdata_o    = {2{storeData_i[15:0]}};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/accessor.sv
// Memory-access stage: takes one executor op, runs a valid/ready memory transaction if needed,
// and holds the writeback result until the writeback stage takes it.
module accessor
    import accessor_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        executor_valid,
    output logic        accessor_ready,
    input  logic [4:0]  executor_rd,
    input  logic [31:0] executor_rd_data,
    input  logic [31:0] executor_mem_addr,
    input  logic [31:0] executor_mem_data,
    input  logic        executor_is_lui,
    input  logic        executor_is_lb,
    input  logic        executor_is_lbu,
    input  logic        executor_is_lh,
    input  logic        executor_is_lhu,
    input  logic        executor_is_lw,
    input  logic        executor_is_sb,
    input  logic        executor_is_sh,
    input  logic        executor_is_sw,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    output logic        accessor_valid,
    input  logic        writeback_ready,
    output logic [4:0]  accessor_rd,
    output logic [31:0] accessor_rd_data,
    output logic        accessor_trap
);

    state_e      state_q, state_d;
    size_e       size_q, size_d;
    logic        isLoad_q, isLoad_d, isStore_q, isStore_d, signed_q, signed_d;
    logic        trap_q, trap_d, gotResp_q, gotResp_d;
    logic [31:0] addr_q, addr_d, storeData_q, storeData_d, result_q, result_d;
    logic [4:0]  rd_q, rd_d;

    logic        isLoadIn, isStoreIn, misalignIn, accept, respNow;
    size_e       sizeIn;
    logic [31:0] loadData;

    accessor_mem_align memAlign (
        .size_i      (size_q),
        .signed_i    (signed_q),
        .addrLow_i   (addr_q[1:0]),
        .storeData_i (storeData_q),
        .rdata_i     (mem_rdata),
        .wdata_o     (mem_wdata),
        .loadData_o  (loadData)
    );

    always_comb begin
        isLoadIn  = executor_is_lb | executor_is_lbu | executor_is_lh | executor_is_lhu | executor_is_lw;
        isStoreIn = executor_is_sb | executor_is_sh | executor_is_sw;
        sizeIn    = SIZE_BYTE;
        if (executor_is_lh | executor_is_lhu | executor_is_sh) begin
            sizeIn = SIZE_HALF;
        end else if (executor_is_lw | executor_is_sw) begin
            sizeIn = SIZE_WORD;
        end
        misalignIn = (isLoadIn | isStoreIn) && isMisaligned(sizeIn, executor_mem_addr[1:0]);
        accept     = executor_valid && accessor_ready;
        respNow    = mem_valid && mem_ready;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            size_q      <= SIZE_BYTE;
            isLoad_q    <= 1'b0;
            isStore_q   <= 1'b0;
            signed_q    <= 1'b0;
            trap_q      <= 1'b0;
            gotResp_q   <= 1'b0;
            addr_q      <= '0;
            storeData_q <= '0;
            result_q    <= '0;
            rd_q        <= '0;
        end else begin
            state_q     <= state_d;
            size_q      <= size_d;
            isLoad_q    <= isLoad_d;
            isStore_q   <= isStore_d;
            signed_q    <= signed_d;
            trap_q      <= trap_d;
            gotResp_q   <= gotResp_d;
            addr_q      <= addr_d;
            storeData_q <= storeData_d;
            result_q    <= result_d;
            rd_q        <= rd_d;
        end
    end

    // A response taken while still in REQ is remembered so WAIT can finish without re-asking memory.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ((isLoadIn | isStoreIn) && !misalignIn) ? REQ : DONE;
            REQ:     state_d = WAIT;
            WAIT:    if (gotResp_q || respNow) state_d = DONE;
            DONE:    if (writeback_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        size_d      = size_q;
        isLoad_d    = isLoad_q;
        isStore_d   = isStore_q;
        signed_d    = signed_q;
        trap_d      = trap_q;
        gotResp_d   = gotResp_q;
        addr_d      = addr_q;
        storeData_d = storeData_q;
        result_d    = result_q;
        rd_d        = rd_q;
        if (accept) begin
            size_d      = sizeIn;
            isLoad_d    = isLoadIn && !misalignIn;
            isStore_d   = isStoreIn && !misalignIn;
            signed_d    = executor_is_lb | executor_is_lh;
            trap_d      = misalignIn;
            gotResp_d   = 1'b0;
            addr_d      = executor_mem_addr;
            storeData_d = executor_mem_data;
            rd_d        = (isStoreIn || misalignIn) ? 5'd0 : executor_rd;
            if (executor_is_lui) begin
                result_d = executor_mem_addr;
            end else if (isLoadIn || isStoreIn) begin
                result_d = '0;
            end else begin
                result_d = executor_rd_data;
            end
        end
        if (respNow) begin
            gotResp_d = 1'b1;
            if (isLoad_q) result_d = loadData;
        end
    end

    always_comb begin
        accessor_ready   = (state_q == IDLE) && !reset;
        accessor_valid   = (state_q == DONE);
        mem_valid        = (state_q == REQ) || ((state_q == WAIT) && !gotResp_q);
        mem_addr         = {addr_q[31:2], 2'b00};
        mem_wstrb        = (mem_valid && isStore_q) ? wstrbFor(size_q, addr_q[1:0]) : WSTRB_NONE;
        accessor_rd      = rd_q;
        accessor_rd_data = result_q;
        accessor_trap    = trap_q;
    end

endmodule

// File: tb/tb_accessor.sv
// Directed bench for the accessor: pass-through, lui, loads, stores, traps, stalls and reset mid-flight.
module tb_accessor;

    localparam logic [8:0] OP_PASS = 9'h000;
    localparam logic [8:0] OP_LUI  = 9'h100;
    localparam logic [8:0] OP_LB   = 9'h080;
    localparam logic [8:0] OP_LBU  = 9'h040;
    localparam logic [8:0] OP_LH   = 9'h020;
    localparam logic [8:0] OP_LHU  = 9'h010;
    localparam logic [8:0] OP_LW   = 9'h008;
    localparam logic [8:0] OP_SB   = 9'h004;
    localparam logic [8:0] OP_SH   = 9'h002;
    localparam logic [8:0] OP_SW   = 9'h001;

    logic        clk = 1'b0;
    logic        reset;
    logic        executor_valid;
    logic        accessor_ready;
    logic [4:0]  executor_rd;
    logic [31:0] executor_rd_data;
    logic [31:0] executor_mem_addr;
    logic [31:0] executor_mem_data;
    logic [8:0]  ops;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        accessor_valid;
    logic        writeback_ready;
    logic [4:0]  accessor_rd;
    logic [31:0] accessor_rd_data;
    logic        accessor_trap;

    int assertCount = 0;
    int failCount   = 0;

    always #5 clk = ~clk;

    accessor dut (
        .clk               (clk),
        .reset             (reset),
        .executor_valid    (executor_valid),
        .accessor_ready    (accessor_ready),
        .executor_rd       (executor_rd),
        .executor_rd_data  (executor_rd_data),
        .executor_mem_addr (executor_mem_addr),
        .executor_mem_data (executor_mem_data),
        .executor_is_lui   (ops[8]),
        .executor_is_lb    (ops[7]),
        .executor_is_lbu   (ops[6]),
        .executor_is_lh    (ops[5]),
        .executor_is_lhu   (ops[4]),
        .executor_is_lw    (ops[3]),
        .executor_is_sb    (ops[2]),
        .executor_is_sh    (ops[1]),
        .executor_is_sw    (ops[0]),
        .mem_valid         (mem_valid),
        .mem_ready         (mem_ready),
        .mem_addr          (mem_addr),
        .mem_wdata         (mem_wdata),
        .mem_wstrb         (mem_wstrb),
        .mem_rdata         (mem_rdata),
        .accessor_valid    (accessor_valid),
        .writeback_ready   (writeback_ready),
        .accessor_rd       (accessor_rd),
        .accessor_rd_data  (accessor_rd_data),
        .accessor_trap     (accessor_trap)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Offers one op at a negedge, lets the next posedge accept it, then withdraws it.
    task automatic applyStimulus(input logic [8:0] op, input logic [31:0] addr, input logic [31:0] data,
                                 input logic [31:0] rdData, input logic [4:0] rd);
        checkOutput("readyBeforeIssue", 32'(accessor_ready), 1);
        ops               = op;
        executor_mem_addr = addr;
        executor_mem_data = data;
        executor_rd_data  = rdData;
        executor_rd       = rd;
        executor_valid    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        executor_valid = 1'b0;
        ops            = OP_PASS;
    endtask

    task automatic serveMem(input string tag, input int delay, input logic [31:0] expAddr,
                            input logic [3:0] expStrb, input bit checkData, input logic [31:0] expWdata,
                            input logic [31:0] rdata);
        for (int i = 0; i <= delay; i++) begin
            checkOutput({tag, ".memValid"}, 32'(mem_valid), 1);
            checkOutput({tag, ".memAddr"}, mem_addr, expAddr);
            checkOutput({tag, ".memWstrb"}, 32'(mem_wstrb), 32'(expStrb));
            checkOutput({tag, ".readyLow"}, 32'(accessor_ready), 0);
            if (checkData) checkOutput({tag, ".memWdata"}, mem_wdata, expWdata);
            if (i == delay) begin
                mem_rdata = rdata;
                mem_ready = 1'b1;
            end
            @(negedge clk);
        end
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        checkOutput({tag, ".memDrop"}, 32'(mem_valid), 0);
    endtask

    task automatic waitValid(input string tag, input int expLatency);
        int cycles = 0;
        while (!accessor_valid && cycles < 8) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput({tag, ".latency"}, cycles, expLatency);
    endtask

    // Holds writeback off for holdCycles while pushing a competing request that must be ignored.
    task automatic checkWriteback(input string tag, input logic [4:0] expRd, input logic [31:0] expData,
                                  input logic expTrap, input int holdCycles);
        for (int i = 0; i <= holdCycles; i++) begin
            writeback_ready  = (i == holdCycles);
            executor_valid   = (i < holdCycles);
            executor_rd      = 5'd31;
            executor_rd_data = 32'hFFFF_FFFF;
            checkOutput({tag, ".valid"}, 32'(accessor_valid), 1);
            checkOutput({tag, ".rd"}, 32'(accessor_rd), 32'(expRd));
            checkOutput({tag, ".data"}, accessor_rd_data, expData);
            checkOutput({tag, ".trap"}, 32'(accessor_trap), 32'(expTrap));
            checkOutput({tag, ".readyLow"}, 32'(accessor_ready), 0);
            @(negedge clk);
        end
        executor_valid  = 1'b0;
        writeback_ready = 1'b0;
        checkOutput({tag, ".validDrop"}, 32'(accessor_valid), 0);
        checkOutput({tag, ".readyBack"}, 32'(accessor_ready), 1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset             = 1'b1;
        executor_valid    = 1'b0;
        executor_rd       = '0;
        executor_rd_data  = '0;
        executor_mem_addr = '0;
        executor_mem_data = '0;
        ops               = OP_PASS;
        mem_ready         = 1'b0;
        mem_rdata         = '0;
        writeback_ready   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset.ready", 32'(accessor_ready), 0);
        checkOutput("reset.valid", 32'(accessor_valid), 0);
        checkOutput("reset.memValid", 32'(mem_valid), 0);
        checkOutput("reset.wstrb", 32'(mem_wstrb), 0);
        checkOutput("reset.rd", 32'(accessor_rd), 0);
        checkOutput("reset.data", accessor_rd_data, 0);
        checkOutput("reset.trap", 32'(accessor_trap), 0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reset.readyAfter", 32'(accessor_ready), 1);

        writeback_ready = 1'b1;
        applyStimulus(OP_PASS, 32'h0, 32'h0, 32'h1234_5678, 5'd5);
        checkOutput("pass.memIdle", 32'(mem_valid), 0);
        checkWriteback("pass", 5'd5, 32'h1234_5678, 1'b0, 0);

        applyStimulus(OP_LUI, 32'hABCD_E000, 32'h0, 32'h5555_5555, 5'd3);
        checkWriteback("lui", 5'd3, 32'hABCD_E000, 1'b0, 0);

        applyStimulus(OP_LB, 32'h0000_0103, 32'h0, 32'h0, 5'd7);
        serveMem("lb", 0, 32'h0000_0100, 4'b0000, 1'b0, 32'h0, 32'h80FF_0000);
        waitValid("lb", 1);
        checkWriteback("lb", 5'd7, 32'hFFFF_FF80, 1'b0, 0);

        applyStimulus(OP_LBU, 32'h0000_0103, 32'h0, 32'h0, 5'd8);
        serveMem("lbu", 0, 32'h0000_0100, 4'b0000, 1'b0, 32'h0, 32'h80FF_0000);
        waitValid("lbu", 1);
        checkWriteback("lbu", 5'd8, 32'h0000_0080, 1'b0, 0);

        applyStimulus(OP_LH, 32'h0000_0102, 32'h0, 32'h0, 5'd10);
        serveMem("lh", 1, 32'h0000_0100, 4'b0000, 1'b0, 32'h0, 32'h80FF_0000);
        waitValid("lh", 0);
        checkWriteback("lh", 5'd10, 32'hFFFF_80FF, 1'b0, 0);

        applyStimulus(OP_LHU, 32'h0000_0100, 32'h0, 32'h0, 5'd11);
        serveMem("lhu", 0, 32'h0000_0100, 4'b0000, 1'b0, 32'h0, 32'h1234_F00D);
        waitValid("lhu", 1);
        checkWriteback("lhu", 5'd11, 32'h0000_F00D, 1'b0, 0);

        applyStimulus(OP_SH, 32'h0000_0202, 32'hAAAA_BEEF, 32'h0, 5'd9);
        serveMem("sh", 0, 32'h0000_0200, 4'b1100, 1'b1, 32'hBEEF_BEEF, 32'h0);
        waitValid("sh", 1);
        checkWriteback("sh", 5'd0, 32'h0, 1'b0, 0);

        applyStimulus(OP_SB, 32'h0000_0201, 32'h1122_3344, 32'h0, 5'd9);
        serveMem("sb", 0, 32'h0000_0200, 4'b0010, 1'b1, 32'h4444_4444, 32'h0);
        waitValid("sb", 1);
        checkWriteback("sb", 5'd0, 32'h0, 1'b0, 0);

        applyStimulus(OP_SW, 32'h0000_0204, 32'hCAFE_F00D, 32'h0, 5'd9);
        serveMem("sw", 0, 32'h0000_0204, 4'b1111, 1'b1, 32'hCAFE_F00D, 32'h0);
        waitValid("sw", 1);
        checkWriteback("sw", 5'd0, 32'h0, 1'b0, 0);

        applyStimulus(OP_LW, 32'h0000_0301, 32'h0, 32'h0, 5'd6);
        checkOutput("lwTrap.memValid", 32'(mem_valid), 0);
        checkWriteback("lwTrap", 5'd0, 32'h0, 1'b1, 0);

        applyStimulus(OP_SH, 32'h0000_0203, 32'h1234_5678, 32'h0, 5'd6);
        checkOutput("shTrap.memValid", 32'(mem_valid), 0);
        checkWriteback("shTrap", 5'd0, 32'h0, 1'b1, 0);

        applyStimulus(OP_LW, 32'h0000_0400, 32'h0, 32'h0, 5'd12);
        serveMem("lwStall", 5, 32'h0000_0400, 4'b0000, 1'b0, 32'h0, 32'hDEAD_BEEF);
        waitValid("lwStall", 0);
        checkWriteback("lwStall", 5'd12, 32'hDEAD_BEEF, 1'b0, 3);

        applyStimulus(OP_LW, 32'h0000_0500, 32'h0, 32'h0, 5'd4);
        @(negedge clk);
        checkOutput("rstWait.memValid", 32'(mem_valid), 1);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rstWait.memDrop", 32'(mem_valid), 0);
        checkOutput("rstWait.noValid", 32'(accessor_valid), 0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rstWait.ready", 32'(accessor_ready), 1);
        checkOutput("rstWait.stillNoValid", 32'(accessor_valid), 0);
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        checkOutput("strayReady.noValid", 32'(accessor_valid), 0);
        checkOutput("strayReady.noMem", 32'(mem_valid), 0);
        checkOutput("strayReady.ready", 32'(accessor_ready), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
